spi_xfer_arbiter: RTL

- Sequences the SPI byte engine (module `spi`) and shares it between two requesters.
- Requester 0 is the CPU MTC0/MFC0 path; requester 1 is a peripheral/DMA port.
- Round-robin grant, one transfer at a time: issue MOSI word, wait for MISO word, return it with a done pulse, or an error on timeout.
- Sits between the SPI register file and the `spi` core.

---
 rtl/spi_xfer_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one SPI word engine between two requesters.
// Round-robin grant, one transfer in flight: load the MOSI word, wait for the
// MISO word (or give up after TIMEOUT cycles), then report back with a
// one-cycle done pulse. Every output is a register; no input reaches an output
// combinationally.
module spi_xfer_arbiter #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] wdata0,
  output logic         done0,
  output logic         err0,
  output logic [W-1:0] rdata0,
  input  logic         req1,
  input  logic [W-1:0] wdata1,
  output logic         done1,
  output logic         err1,
  output logic [W-1:0] rdata1,
  output logic         busy,
  input  logic         spi_tx_ready,
  output logic [W-1:0] spi_tx_data,
  output logic         spi_tx_valid,
  input  logic [W-1:0] spi_rx_data,
  input  logic         spi_rx_valid
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRx, StDone} state_e;

  // Counter value on the last WAIT_RX cycle before giving up.
  localparam logic [TW-1:0] CntLast = TW'(TIMEOUT - 1);

  state_e        state_q;
  logic          winner_q;
  logic          last_grant_q;
  logic [TW-1:0] cnt_q;
  logic          pick1;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    pick1 = req1 && (!req0 || !last_grant_q);
  end

  // Transfer sequencer; owns the state and every registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      done0        <= 1'b0;
      err0         <= 1'b0;
      rdata0       <= '0;
      done1        <= 1'b0;
      err1         <= 1'b0;
      rdata1       <= '0;
      busy         <= 1'b0;
      spi_tx_data  <= '0;
      spi_tx_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if ((req0 || req1) && spi_tx_ready) begin
            winner_q     <= pick1;
            spi_tx_data  <= pick1 ? wdata1 : wdata0;
            spi_tx_valid <= 1'b1;
            busy         <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          spi_tx_valid <= 1'b0;
          cnt_q        <= '0;
          state_q      <= StWaitRx;
        end
        StWaitRx: begin
          // A word arriving on the limit cycle still counts as success.
          if (spi_rx_valid) begin
            if (winner_q) begin
              rdata1 <= spi_rx_data;
              done1  <= 1'b1;
              err1   <= 1'b0;
            end else begin
              rdata0 <= spi_rx_data;
              done0  <= 1'b1;
              err0   <= 1'b0;
            end
            state_q <= StDone;
          end else if (cnt_q == CntLast) begin
            if (winner_q) begin
              done1 <= 1'b1;
              err1  <= 1'b1;
            end else begin
              done0 <= 1'b1;
              err0  <= 1'b1;
            end
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        StDone: begin
          done0        <= 1'b0;
          err0         <= 1'b0;
          done1        <= 1'b0;
          err1         <= 1'b0;
          busy         <= 1'b0;
          last_grant_q <= winner_q;
          state_q      <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
